// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default operand width.
package sub_pkg;
  localparam int SUB_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: diff = in1 - in2 - borrow_in, LSB first, one bit per clock.
// Optional signed-overflow flag output enabled by defining SUB_SIGNED_OVF_EN.
module serial_subtractor_4bit
  import sub_pkg::*;
#(
  parameter  int WIDTH = SUB_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
`ifdef SUB_SIGNED_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] in1_sr;
  logic [WIDTH-1:0] in2_sr;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt;
  logic             fs_d;
  logic             fs_bo;

`ifdef SUB_SIGNED_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  full_subtractor u_fs (
    .a    (in1_sr[0]),
    .b    (in2_sr[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      in1_sr     <= '0;
      in2_sr     <= '0;
      borrow_q   <= 1'b0;
      cnt        <= '0;
`ifdef SUB_SIGNED_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in1_sr   <= in1;
            in2_sr   <= in2;
            borrow_q <= borrow_in;
            diff     <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
`ifdef SUB_SIGNED_OVF_EN
            a_msb    <= in1[WIDTH-1];
            b_msb    <= in2[WIDTH-1];
            ovf      <= 1'b0;
`endif
          end else begin
            // First cycle after reset release lands here with in_ready still low.
            in_ready <= 1'b1;
          end
        end

        RUN: begin
          // New bit enters at the MSB so bit 0 ends up at diff[0] after WIDTH shifts.
          diff     <= {fs_d, diff[WIDTH-1:1]};
          in1_sr   <= in1_sr >> 1;
          in2_sr   <= in2_sr >> 1;
          borrow_q <= fs_bo;
          cnt      <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            state      <= DONE;
            busy       <= 1'b0;
            out_valid  <= 1'b1;
            borrow_out <= fs_bo;
`ifdef SUB_SIGNED_OVF_EN
            // fs_d is the result sign bit on the final step.
            ovf        <= (a_msb != b_msb) && (fs_d != a_msb);
`endif
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
`ifdef SUB_SIGNED_OVF_EN
            ovf       <= 1'b0;
`endif
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Directed + randomized bench for serial_subtractor_4bit against an arithmetic reference model.
module tb_serial_subtractor_4bit;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         borrow_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         busy;
`ifdef SUB_SIGNED_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  serial_subtractor_4bit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in2        (in2),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
`ifdef SUB_SIGNED_OVF_EN
    .ovf        (ovf),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one subtraction through both handshakes and checks it against plain arithmetic.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input int hold, input bit pulse);
    int          lat;
    int          waitc;
    int          full;
    logic [W-1:0] exp_diff;
    logic         exp_bo;
    full     = int'(a) - int'(b) - int'(bin);
    exp_diff = W'(full);
    exp_bo   = (full < 0);

    waitc = 0;
    while (!in_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);

    in1 = a; in2 = b; borrow_in = bin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in1 = ~a; in2 = ~b; borrow_in = ~bin;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("in_ready_in_run", {31'd0, in_ready}, 32'd0);

    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, W);
    chk("diff", {28'd0, diff}, {28'd0, exp_diff});
    chk("borrow_out", {31'd0, borrow_out}, {31'd0, exp_bo});
    chk("busy_in_done", {31'd0, busy}, 32'd0);
`ifdef SUB_SIGNED_OVF_EN
    chk("ovf", {31'd0, ovf}, {31'd0, (a[W-1] != b[W-1]) && (exp_diff[W-1] != a[W-1])});
`endif

    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 2) begin
        in1 = W'($urandom); in2 = W'($urandom); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_diff", {28'd0, diff}, {28'd0, exp_diff});
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;

    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_take", {31'd0, out_valid}, 32'd0);
    chk("in_ready_after_take", {31'd0, in_ready}, 32'd1);
    chk("diff_held_idle", {28'd0, diff}, {28'd0, exp_diff});
`ifdef SUB_SIGNED_OVF_EN
    chk("ovf_idle", {31'd0, ovf}, 32'd0);
`endif
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_diff", {28'd0, diff}, 32'd0);
    chk("rst_borrow_out", {31'd0, borrow_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("in_ready_after_release", {31'd0, in_ready}, 32'd1);

    // Directed cases
    do_op(4'b1011, 4'b0011, 1'b0, 0, 1'b0);
    do_op(4'b0000, 4'b0011, 1'b0, 1, 1'b0);
    do_op(4'b0000, 4'b0000, 1'b1, 0, 1'b0);
    do_op(4'b1011, 4'b0000, 1'b0, 0, 1'b0);
    do_op(4'b0111, 4'b1000, 1'b0, 0, 1'b0);
    do_op(4'b0011, 4'b0001, 1'b0, 0, 1'b0);

    // Backpressure with an in_valid pulse that must be ignored
    do_op(4'b1100, 4'b0101, 1'b1, 10, 1'b1);
    repeat (2) @(negedge clk);
    chk("no_spurious_accept_busy", {31'd0, busy}, 32'd0);
    chk("no_spurious_accept_ready", {31'd0, in_ready}, 32'd1);

    // Reset mid-RUN
    in1 = 4'b1111; in2 = 4'b0001; borrow_in = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrun_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_diff", {28'd0, diff}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (8) begin
      @(negedge clk);
      chk("abort_hold_out_valid", {31'd0, out_valid}, 32'd0);
    end
    rst_n = 1'b1;
    do_op(4'b0101, 4'b0001, 1'b0, 0, 1'b0);

    // Randomized operands, borrow and backpressure
    for (int k = 0; k < 24; k++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/serial_subtractor_4bit.md
Name: serial_subtractor_4bit

Overview:
- Bit-serial N-bit subtractor computing in1 - in2 - borrow_in, one bit per clock, LSB first.
- Arithmetic inverse of the team's ripple adder_4bit. Used where area matters more than latency, and as a self-check partner: (a + b) - b == a.
- Operands enter through a valid/ready start handshake. Result is presented through a valid/ready output handshake.

Parameters:
- WIDTH, 4, operand and result width in bits (>= 2).
- CNT_W, $clog2(WIDTH)+1, bit-position counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/borrow_in valid
- in_ready  output  1  block can accept operands
- in1  input  WIDTH  minuend
- in2  input  WIDTH  subtrahend
- borrow_in  input  1  initial borrow
- out_valid  output  1  diff/borrow_out valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  in1 - in2 - borrow_in, modulo 2^WIDTH
- borrow_out  output  1  final borrow (1 when in1 < in2 + borrow_in, unsigned)
- busy  output  1  high in RUN state

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0 while rst_n low, then 1 from the first clk edge after release; out_valid=0, diff=0, borrow_out=0, busy=0, counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid&&in_ready: latch in1, in2 into shift registers, latch borrow_in into the borrow flop, clear diff, counter=0, go to RUN.
- RUN: in_ready=0, busy=1.
  - Each cycle: take bit a=in1_sr[0], b=in2_sr[0], borrow flop bi.
  - d=a^b^bi; bo=(~a&b)|(~(a^b)&bi).
  - Shift d into diff MSB side (after WIDTH shifts, bit 0 lands at diff[0]). Shift operand registers right. borrow flop<=bo. Counter++.
  - When counter==WIDTH-1: go to DONE that edge, borrow_out<=bo.
- DONE: out_valid=1; diff/borrow_out stable.
  - On out_ready: out_valid falls next edge, go to IDLE.
  - out_valid holds indefinitely under backpressure.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge. Throughput is one result per WIDTH+2 cycles minimum (accept, WIDTH run, handoff).
- in_valid is ignored (not accepted, no state change) in RUN and DONE. Inputs change freely after acceptance.
- diff holds its last value in IDLE until the next acceptance clears it.
- Reset asserted mid-RUN or mid-DONE: immediate abort, all outputs to reset values, no partial result is ever flagged valid.
- No X propagation: all registers reset.

Optional Feature:
- Macro SUB_SIGNED_OVF_EN.
- Defined: adds output port ovf (1 bit). Set in DONE when signed two's-complement overflow occurred, i.e. sign(in1)!=sign(in2) && sign(diff)!=sign(in1). Latched alongside borrow_out (requires latching the operand MSBs at acceptance). ovf is 0 at reset and in IDLE.
- Undefined: port absent, no extra flops.

Decomposition:
- Package sub_pkg: state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default constant.
- One natural sub-module: full_subtractor (a, b, bin -> d, bout), combinational, instantiated once in the RUN datapath.

Test Plan:
- in1=1011, in2=0011, borrow_in=0 -> diff=1000, borrow_out=0, out_valid exactly 4 cycles after accept.
- in1=0000, in2=0011, borrow_in=0 -> diff=1101, borrow_out=1.
- in1=0000, in2=0000, borrow_in=1 -> diff=1111, borrow_out=1. Then in1=1011, in2=0000 -> diff=1011, borrow_out=0.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid, diff stay stable, in_ready=0, and a new in_valid pulse during this window is not accepted.
- Reset mid-RUN: rst_n low at cycle 2 of RUN -> out_valid=0, diff=0 immediately. Next op 0101-0001 gives 0100.
- With SUB_SIGNED_OVF_EN: 0111-1000 -> diff=1111, borrow_out=1, ovf=1. And 0011-0001 -> diff=0010, ovf=0.
